// File: rtl/uart_tx_arbiter.sv
// Two-source arbiter in front of a single UART transmitter. It hands out whole
// messages with a round-robin tie-break and an inactivity timeout on held locks.
module uart_tx_arbiter #(
  parameter int DBIT    = 8,
  parameter int TO_W    = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_req0_valid,
  input  logic [DBIT-1:0] i_req0_data,
  input  logic            i_req0_last,
  output logic            o_req0_ready,
  input  logic            i_req1_valid,
  input  logic [DBIT-1:0] i_req1_data,
  input  logic            i_req1_last,
  output logic            o_req1_ready,
  output logic            o_tx_start,
  output logic [DBIT-1:0] o_tx_data,
  input  logic            i_tx_done_tick,
  output logic            o_owner,
  output logic            o_busy,
  output logic            o_timeout
);

  // Handshake: a byte moves on a rising edge where valid & ready are both high;
  // ready is a function of state, round-robin pointer and valids only.
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_HOLD} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              last_owner_q, last_owner_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [DBIT-1:0]   data_q, data_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              accept;
  logic              sel;
  logic              owner_valid;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      last_owner_q <= 1'b1;
      owner_q      <= 1'b0;
      last_q       <= 1'b0;
      data_q       <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    last_d       = last_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    o_req0_ready = 1'b0;
    o_req1_ready = 1'b0;
    o_tx_start   = 1'b0;
    o_timeout    = 1'b0;
    owner_valid  = owner_q ? i_req1_valid : i_req0_valid;

    case (state_q)
      S_IDLE: begin
        // On a tie the requester not named by last_owner wins.
        if (i_req0_valid && (!i_req1_valid || last_owner_q)) begin
          o_req0_ready = 1'b1;
        end else if (i_req1_valid) begin
          o_req1_ready = 1'b1;
        end
      end
      S_START: begin
        o_tx_start = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (i_tx_done_tick) begin
          if (last_q) begin
            last_owner_d = owner_q;
            state_d      = S_IDLE;
          end else begin
            cnt_d   = '0;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        o_req0_ready = ~owner_q;
        o_req1_ready = owner_q;
        if (!owner_valid) begin
          if (cnt_q == TO_LAST) begin
            o_timeout    = 1'b1;
            last_owner_d = owner_q;
            state_d      = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    accept = (o_req0_ready && i_req0_valid) || (o_req1_ready && i_req1_valid);
    sel    = o_req1_ready && i_req1_valid;
    if (accept) begin
      owner_d = sel;
      data_d  = sel ? i_req1_data : i_req0_data;
      last_d  = sel ? i_req1_last : i_req0_last;
      state_d = S_START;
    end
  end

  assign o_tx_data = data_q;
  assign o_owner   = owner_q;
  assign o_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transaction-level reference model, randomized
// message traffic, a mock TX core and a byte scoreboard.
module tb_uart_tx_arbiter;
  localparam int DBIT    = 8;
  localparam int TO_W    = 4;
  localparam int TIMEOUT = 8;

  logic            clk, rst;
  logic            v0, l0, v1, l1, r0, r1;
  logic [DBIT-1:0] d0, d1, tx_data;
  logic            tx_start, done, owner, busy, tmo;

  uart_tx_arbiter #(.DBIT(DBIT), .TO_W(TO_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_req0_valid(v0), .i_req0_data(d0), .i_req0_last(l0), .o_req0_ready(r0),
    .i_req1_valid(v1), .i_req1_data(d1), .i_req1_last(l1), .o_req1_ready(r1),
    .o_tx_start(tx_start), .o_tx_data(tx_data), .i_tx_done_tick(done),
    .o_owner(owner), .o_busy(busy), .o_timeout(tmo)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [DBIT:0] exp_q[$];            // {owner, data} of each accepted byte
  logic [DBIT:0] src_q0[$], src_q1[$]; // {last, data} waiting at each source

  // reference model: message-level view of who may talk and what is in flight
  bit              m_start, m_inflight, m_locked, m_last, m_prefer0, m_owner;
  int              m_idle;
  logic [DBIT-1:0] m_data;

  bit spur_en, rand_gaps, acc_seen0, acc_seen1;
  int tx_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_ready(); // {ready1, ready0}
    if (m_start || m_inflight) return 2'b00;
    if (m_locked) return m_owner ? 2'b10 : 2'b01;
    if (v0 && v1) return m_prefer0 ? 2'b01 : 2'b10;
    return {v1, v0};
  endfunction

  function automatic bit exp_timeout();
    return m_locked && !(m_owner ? v1 : v0) && (m_idle == TIMEOUT - 1);
  endfunction

  task automatic model_reset();
    m_start = 0; m_inflight = 0; m_locked = 0; m_last = 0;
    m_prefer0 = 1; m_owner = 0; m_idle = 0; m_data = '0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [1:0] r;
    r = exp_ready();
    if (m_start) begin
      m_start    = 0;
      m_inflight = 1;
    end else if (m_inflight) begin
      if (done) begin
        m_inflight = 0;
        if (m_last) begin
          m_locked  = 0;
          m_prefer0 = m_owner;
        end else begin
          m_locked = 1;
          m_idle   = 0;
        end
      end
    end else if ((r[0] && v0) || (r[1] && v1)) begin
      m_owner = r[1] && v1;
      m_data  = m_owner ? d1 : d0;
      m_last  = m_owner ? l1 : l0;
      exp_q.push_back({m_owner, m_data});
      m_start  = 1;
      m_locked = 0;
    end else if (m_locked) begin
      if (m_idle == TIMEOUT - 1) begin
        m_locked  = 0;
        m_prefer0 = m_owner;
      end else begin
        m_idle++;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // monitor + scoreboard
  initial begin
    logic [DBIT+5:0] exp_c, act_c;
    logic [DBIT:0]   exp_e;
    forever begin
      @(negedge clk);
      #3;
      exp_c = {exp_ready(), m_start, (m_start || m_inflight || m_locked), exp_timeout(), m_owner, m_data};
      act_c = {r1, r0, tx_start, busy, tmo, owner, tx_data};
      check("ctrl{rdy1,rdy0,start,busy,timeout,owner,data}", 32'(act_c), 32'(exp_c));
      acc_seen0 = !rst && v0 && r0;
      acc_seen1 = !rst && v1 && r1;
      if (tx_start) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_byte: start with owner %0d data %h, expected no start", owner, tx_data);
        end else begin
          exp_e = exp_q.pop_front();
          check("sb_byte{owner,data}", 32'({owner, tx_data}), 32'(exp_e));
        end
      end
    end
  end

  function automatic int pick_gap();
    if (!rand_gaps) return 0;
    if ($urandom_range(0, 9) == 0) return TIMEOUT + 2;
    return int'($urandom_range(0, 2));
  endfunction

  // requester drivers
  initial begin
    int gap0, gap1;
    gap0 = 0;
    gap1 = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        v0 = 0; v1 = 0; gap0 = 0; gap1 = 0;
        src_q0.delete();
        src_q1.delete();
      end else begin
        if (acc_seen0) begin
          void'(src_q0.pop_front());
          v0 = 0;
          gap0 = pick_gap();
        end
        if (acc_seen1) begin
          void'(src_q1.pop_front());
          v1 = 0;
          gap1 = pick_gap();
        end
        if (!v0) begin
          if (gap0 > 0) gap0--;
          else if (src_q0.size() > 0) begin
            v0 = 1;
            {l0, d0} = src_q0[0];
          end
        end
        if (!v1) begin
          if (gap1 > 0) gap1--;
          else if (src_q1.size() > 0) begin
            v1 = 1;
            {l1, d1} = src_q1[0];
          end
        end
      end
    end
  end

  // mock TX core: done tick a few cycles after each start, plus spurious ticks
  initial begin
    done   = 0;
    tx_cnt = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        done   = 0;
        tx_cnt = 0;
      end else if (tx_start) begin
        tx_cnt = int'($urandom_range(1, 5));
        done   = spur_en && ($urandom_range(0, 1) == 1);
      end else if (tx_cnt > 0) begin
        tx_cnt--;
        done = (tx_cnt == 0);
      end else begin
        done = spur_en && !m_inflight && ($urandom_range(0, 7) == 0);
      end
    end
  end

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (n < budget && !(src_q0.size() == 0 && src_q1.size() == 0 && !v0 && !v1 &&
           !m_start && !m_inflight && !m_locked && exp_q.size() == 0)) begin
      @(negedge clk);
      #4;
      n++;
    end
    n_checks++;
    if (n >= budget) begin
      n_fail++;
      $display("FAIL drain_%s: still busy after %0d cycles, pending expected bytes %0d", name, n, exp_q.size());
    end
  endtask

  task automatic push_msg(input bit src, input int len);
    logic [DBIT:0] e;
    for (int i = 0; i < len; i++) begin
      e = {(i == len - 1), DBIT'($urandom_range(0, 255))};
      if (src) src_q1.push_back(e);
      else src_q0.push_back(e);
    end
  endtask

  // main sequence
  initial begin
    int n;
    rst = 1; v0 = 0; v1 = 0; d0 = '0; d1 = '0; l0 = 0; l1 = 0;
    spur_en = 0; rand_gaps = 0;
    repeat (3) @(negedge clk);
    #4;
    check("reset_outputs", 32'({r0, r1, tx_start, busy, tmo, owner, tx_data}), 32'd0);
    @(negedge clk);
    #2 rst = 0;

    src_q0.push_back({1'b1, 8'hA5});
    wait_idle("single", 200);

    src_q0.push_back({1'b1, 8'h11});
    src_q1.push_back({1'b1, 8'h22});
    wait_idle("tie1", 200);
    src_q0.push_back({1'b1, 8'h33});
    src_q1.push_back({1'b1, 8'h44});
    wait_idle("tie2", 200);

    src_q0.push_back({1'b0, 8'h01});
    src_q0.push_back({1'b0, 8'h02});
    src_q0.push_back({1'b1, 8'h03});
    src_q1.push_back({1'b1, 8'h99});
    wait_idle("lock", 300);

    src_q0.push_back({1'b0, 8'h01});
    src_q1.push_back({1'b1, 8'h55});
    wait_idle("timeout", 300);

    spur_en = 1;
    repeat (30) @(negedge clk);
    src_q1.push_back({1'b1, 8'h66});
    wait_idle("spurious", 300);

    src_q0.push_back({1'b1, 8'h77});
    n = 0;
    while (!m_inflight && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_wait", 32'(m_inflight), 32'd1);
    @(negedge clk);
    #2 rst = 1;
    #2;
    check("reset_in_wait", 32'({tx_start, busy, tmo, owner, tx_data}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 0;
    src_q0.push_back({1'b1, 8'h5A});
    wait_idle("after_reset", 200);

    rand_gaps = 1;
    for (int b = 0; b < 60; b++) begin
      if ($urandom_range(0, 1) == 1) push_msg(1'b0, int'($urandom_range(1, 4)));
      if ($urandom_range(0, 1) == 1) push_msg(1'b1, int'($urandom_range(1, 4)));
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    wait_idle("random", 20000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
